// File: rtl/crossbar_sched.sv
// Round-robin output scheduler for an N x N registered crossbar (N = 1 << W).
// Define XBAR_SCHED_LOCK_EN to hold an output for a whole packet (req_last ends it).
module crossbar_sched #(
  parameter int W = 4,
  localparam int N = 1 << W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_valid,
  input  logic [W-1:0] req_dst [N],
  input  logic [N-1:0] req_last,
  output logic [N-1:0] grant,
  output logic [W-1:0] sel [N],
  output logic [N-1:0] o_valid
);

  // Handshake: input k presents a beat with req_valid[k] and holds valid/dst/last/data
  // stable until grant[k]; a beat moves in the cycle where req_valid[k] && grant[k].

  logic [W-1:0] ptr [N];
  logic [N-1:0] cand [N];
  logic [N-1:0] barred;
  logic [N-1:0] has_win;
  logic [W-1:0] win [N];
  logic [N-1:0] v1;

`ifdef XBAR_SCHED_LOCK_EN
  logic [N-1:0] locked;
  logic [W-1:0] owner [N];
`else
  logic unused_last;
  assign unused_last = ^req_last;
`endif

  // An owner that strays to another destination while holding a lock is granted nowhere.
  always_comb begin
    barred = '0;
`ifdef XBAR_SCHED_LOCK_EN
    for (int j = 0; j < N; j++) begin
      if (locked[j] && (req_dst[owner[j]] != W'(j))) barred[owner[j]] = 1'b1;
    end
`endif
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        cand[j][k] = req_valid[k] && !barred[k] && (req_dst[k] == W'(j));
      end
    end
  end

  always_comb begin
    logic [W-1:0] idx;
    logic         rr_found;
    logic [W-1:0] rr_idx;
    idx = '0;
    for (int j = 0; j < N; j++) begin
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int off = 0; off < N; off++) begin
        idx = ptr[j] + W'(off);
        if (!rr_found && cand[j][idx]) begin
          rr_found = 1'b1;
          rr_idx   = idx;
        end
      end
      has_win[j] = rr_found;
      win[j]     = rr_idx;
`ifdef XBAR_SCHED_LOCK_EN
      if (locked[j]) begin
        has_win[j] = cand[j][owner[j]];
        win[j]     = owner[j];
      end
`endif
      has_win[j] = has_win[j] && rst_n;
    end
  end

  always_comb begin
    grant = '0;
    for (int j = 0; j < N; j++) begin
      sel[j] = has_win[j] ? win[j] : '0;
      if (has_win[j]) grant[win[j]] = 1'b1;
    end
  end

  // Stage 1 lines up with the crossbar's select register, stage 2 with its output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= '0;
      o_valid <= '0;
      for (int j = 0; j < N; j++) ptr[j] <= '0;
`ifdef XBAR_SCHED_LOCK_EN
      locked <= '0;
      for (int j = 0; j < N; j++) owner[j] <= '0;
`endif
    end else begin
      v1      <= has_win;
      o_valid <= v1;
      for (int j = 0; j < N; j++) begin
        if (has_win[j]) begin
`ifdef XBAR_SCHED_LOCK_EN
          if (req_last[win[j]]) begin
            locked[j] <= 1'b0;
            ptr[j]    <= win[j] + W'(1);
          end else begin
            locked[j] <= 1'b1;
            owner[j]  <= win[j];
          end
`else
          ptr[j] <= win[j] + W'(1);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_crossbar_sched.sv
// Directed bench for crossbar_sched (N=16): reset, permutation, round-robin, wrap, lock, reset mid-packet.
// Lock-dependent expectations follow XBAR_SCHED_LOCK_EN.
module tb_crossbar_sched;

  localparam int W = 4;
  localparam int N = 16;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [W-1:0] req_dst [N];
  logic [N-1:0] req_last;
  logic [N-1:0] grant;
  logic [W-1:0] sel [N];
  logic [N-1:0] o_valid;
  logic [63:0]  sel_flat;

  int vectors    = 0;
  int miscompares = 0;
  logic [N-1:0] exp_q[$];

  crossbar_sched #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_dst(req_dst),
    .req_last(req_last), .grant(grant), .sel(sel), .o_valid(o_valid)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    sel_flat = '0;
    for (int j = 0; j < N; j++) sel_flat[4*j +: 4] = sel[j];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    req_valid = '0;
    req_last  = '1;
    for (int k = 0; k < N; k++) req_dst[k] = '0;
  endtask

  task automatic set_req(input int k, input int dst, input logic last);
    req_valid[k] = 1'b1;
    req_dst[k]   = W'(dst);
    req_last[k]  = last;
  endtask

  // one cycle: check combinational grant/sel, pipelined o_valid, then advance past the edge
  task automatic step(input string tag, input logic [N-1:0] eg, input logic [N-1:0] mask,
                      input logic [63:0] es);
    logic [N-1:0] eov;
    @(negedge clk);
    eov = exp_q.pop_front();
    exp_q.push_back(mask);
    check({tag, "_grant"}, 64'(grant), 64'(eg));
    check({tag, "_sel"}, sel_flat, es);
    check({tag, "_ovalid"}, 64'(o_valid), 64'(eov));
    @(posedge clk);
    #1;
  endtask

  task automatic check_in_reset(input string tag);
    @(negedge clk);
    check({tag, "_grant"}, 64'(grant), 64'h0);
    check({tag, "_sel"}, sel_flat, 64'h0);
    check({tag, "_ovalid"}, 64'(o_valid), 64'h0);
  endtask

  initial begin
    logic [63:0] perm_sel;
    int order [6];
    order = '{2, 5, 9, 2, 5, 9};
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // reset: everyone requests output 0, nothing may be granted
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    check_in_reset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q = '{16'h0, 16'h0};
    step("rel0", 16'h0001, 16'h0001, 64'h0);
    step("rel1", 16'h0002, 16'h0001, 64'h1);
    idle();
    step("idle0", 16'h0, 16'h0, 64'h0);
    step("idle1", 16'h0, 16'h0, 64'h0);
    step("idle2", 16'h0, 16'h0, 64'h0);

    // permutation k -> 15-k
    perm_sel = '0;
    for (int k = 0; k < N; k++) begin
      set_req(k, 15 - k, 1'b1);
      perm_sel[4*k +: 4] = 4'(15 - k);
    end
    for (int c = 0; c < 4; c++) step("perm", 16'hFFFF, 16'hFFFF, perm_sel);

    // contention on output 3 (ptr[3] = 13 after the permutation)
    idle();
    set_req(2, 3, 1'b1);
    set_req(5, 3, 1'b1);
    set_req(9, 3, 1'b1);
    for (int c = 0; c < 6; c++)
      step("rr", 16'(1 << order[c]), 16'h0008, 64'(order[c]) << 12);

    // wrap-around on output 3
    idle();
    set_req(14, 3, 1'b1);
    step("wrap14", 16'h4000, 16'h0008, 64'd14 << 12);
    req_valid[14] = 1'b0;
    set_req(15, 3, 1'b1);
    set_req(0, 3, 1'b1);
    step("wrap15", 16'h8000, 16'h0008, 64'd15 << 12);
    step("wrap0", 16'h0001, 16'h0008, 64'd0);
    req_valid[0] = 1'b0;
    step("alone15a", 16'h8000, 16'h0008, 64'd15 << 12);
    step("alone15b", 16'h8000, 16'h0008, 64'd15 << 12);

    // packet lock on output 7 (ptr[7] moved to 2 first)
    idle();
    set_req(1, 7, 1'b1);
    step("lk_pre", 16'h0002, 16'h0080, 64'd1 << 28);
    set_req(4, 7, 1'b0);
`ifdef XBAR_SCHED_LOCK_EN
    step("lk_b1", 16'h0010, 16'h0080, 64'd4 << 28);
    step("lk_b2", 16'h0010, 16'h0080, 64'd4 << 28);
    req_last[4] = 1'b1;
    step("lk_b3", 16'h0010, 16'h0080, 64'd4 << 28);
    req_valid[4] = 1'b0;
    step("lk_in1", 16'h0002, 16'h0080, 64'd1 << 28);
`else
    step("nl_4a", 16'h0010, 16'h0080, 64'd4 << 28);
    step("nl_1a", 16'h0002, 16'h0080, 64'd1 << 28);
    step("nl_4b", 16'h0010, 16'h0080, 64'd4 << 28);
    req_last[4] = 1'b1;
    step("nl_1b", 16'h0002, 16'h0080, 64'd1 << 28);
`endif

    // reset in the middle of a packet from input 4
    set_req(1, 7, 1'b1);
    set_req(4, 7, 1'b0);
    step("mid_b1", 16'h0010, 16'h0080, 64'd4 << 28);
    rst_n = 1'b0;
    check_in_reset("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q = '{16'h0, 16'h0};
    step("mid_rel1", 16'h0002, 16'h0080, 64'd1 << 28);
    step("mid_rel4", 16'h0010, 16'h0080, 64'd4 << 28);
    idle();
    step("flush0", 16'h0, 16'h0, 64'h0);
    step("flush1", 16'h0, 16'h0, 64'h0);
    step("flush2", 16'h0, 16'h0, 64'h0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    miscompares++;
    $display("FAIL timeout vectors=%0d", vectors);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
